// File: rtl/init_sequencer.sv
// Power-up initialiser: holds the core, zero-fills the register bank and data memory,
// optionally reads memory back (macro INIT_SEQ_VERIFY_EN), then reports done.
//
// state  | meaning
// ARM    | one-cycle setup after reset or restart; core held, no writes
// CLEAR  | cnt sweeps 0..max(REG_SIZE,MEMORY_SIZE)-1 writing FILL_VALUE
// VERIFY | cnt sweeps 0..MEMORY_SIZE; reads back memory, flags first bad word
// DONE   | core released; waits for start
module init_sequencer #(
  parameter int BITS        = 8,
  parameter int REG_SIZE    = 4,
  parameter int MEMORY_SIZE = 256,
  parameter logic [BITS-1:0] FILL_VALUE = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  output logic core_hold,
  output logic reg_we,
  output logic [((REG_SIZE > 1) ? $clog2(REG_SIZE) : 1)-1:0] reg_addr,
  output logic [BITS-1:0] reg_data,
  output logic mem_we,
  output logic [((MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1)-1:0] mem_addr,
  output logic [BITS-1:0] mem_data,
  input  logic [BITS-1:0] mem_rdata,
  output logic err,
  output logic [((MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1)-1:0] err_addr
);

  localparam int REG_AW   = (REG_SIZE > 1) ? $clog2(REG_SIZE) : 1;
  localparam int MEM_AW   = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
  localparam int MAX_SIZE = (REG_SIZE > MEMORY_SIZE) ? REG_SIZE : MEMORY_SIZE;
  localparam int CNT_W    = $clog2(MAX_SIZE) + 1;

  localparam logic [CNT_W-1:0] REG_LIMIT  = CNT_W'(REG_SIZE);
  localparam logic [CNT_W-1:0] MEM_LIMIT  = CNT_W'(MEMORY_SIZE);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(MAX_SIZE - 1);

  localparam logic [1:0] ARM    = 2'd0;
  localparam logic [1:0] CLEAR  = 2'd1;
`ifdef INIT_SEQ_VERIFY_EN
  localparam logic [1:0] VERIFY = 2'd2;
`endif
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARM;
      cnt   <= '0;
    end else begin
      case (state)
        ARM: begin
          state <= CLEAR;
          cnt   <= '0;
        end
        CLEAR: begin
          if (cnt == CLEAR_LAST) begin
            cnt <= '0;
`ifdef INIT_SEQ_VERIFY_EN
            state <= VERIFY;
`else
            state <= DONE;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`ifdef INIT_SEQ_VERIFY_EN
        // One extra cycle past the last address to catch the final read-back word.
        VERIFY: begin
          if (cnt == MEM_LIMIT) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif
        DONE: begin
          cnt <= '0;
          if (start) state <= ARM;
        end
        default: begin
          state <= ARM;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef INIT_SEQ_VERIFY_EN
  logic [CNT_W-1:0] chk_cnt;
  assign chk_cnt = cnt - CNT_W'(1);

  // mem_rdata belongs to the address presented one cycle earlier (cnt-1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err      <= 1'b0;
      err_addr <= '0;
    end else if (state == DONE && start) begin
      err      <= 1'b0;
      err_addr <= '0;
    end else if (state == VERIFY && cnt != '0 && !err && mem_rdata != FILL_VALUE) begin
      err      <= 1'b1;
      err_addr <= chk_cnt[MEM_AW-1:0];
    end
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign err      = 1'b0;
  assign err_addr = '0;
`endif

  always_comb begin
    busy     = (state != DONE);
    done     = (state == DONE);
    reg_we   = 1'b0;
    mem_we   = 1'b0;
    reg_addr = '0;
    mem_addr = '0;
    reg_data = FILL_VALUE;
    mem_data = FILL_VALUE;
    if (state == CLEAR) begin
      reg_we   = (cnt < REG_LIMIT);
      mem_we   = (cnt < MEM_LIMIT);
      reg_addr = cnt[REG_AW-1:0];
      mem_addr = cnt[MEM_AW-1:0];
    end
`ifdef INIT_SEQ_VERIFY_EN
    if (state == VERIFY) mem_addr = cnt[MEM_AW-1:0];
`endif
  end

  assign core_hold = busy;

endmodule

// File: tb/tb_init_sequencer.sv
// Self-checking bench for init_sequencer: per-cycle scoreboard of expected control outputs
// for a 4x16 instance and an 8x4 instance, plus error-flag and reset checks.
module tb_init_sequencer;

`ifdef INIT_SEQ_VERIFY_EN
  localparam bit VER = 1'b1;
  localparam logic       EXP_ERR      = 1'b1;
  localparam logic [3:0] EXP_ERR_ADDR = 4'd7;
`else
  localparam bit VER = 1'b0;
  localparam logic       EXP_ERR      = 1'b0;
  localparam logic [3:0] EXP_ERR_ADDR = 4'd0;
`endif

  localparam int DONE_K_A = VER ? 34 : 17;
  localparam int DONE_K_B = VER ? 14 : 9;
  localparam int N_A = DONE_K_A + 3;
  localparam int N_B = DONE_K_B + 3;

  typedef struct packed {
    logic busy;
    logic done;
    logic reg_we;
    logic mem_we;
    logic chk_r;
    logic chk_m;
    logic [3:0] reg_addr;
    logic [3:0] mem_addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, rst_n_b, start, start_b, inject;

  logic busy_a, done_a, core_hold_a, reg_we_a, mem_we_a, err_a;
  logic [1:0] reg_addr_a;
  logic [3:0] mem_addr_a, err_addr_a;
  logic [7:0] reg_data_a, mem_data_a, rdata_a;

  logic busy_b, done_b, core_hold_b, reg_we_b, mem_we_b, err_b;
  logic [2:0] reg_addr_b;
  logic [1:0] mem_addr_b, err_addr_b;
  logic [7:0] reg_data_b, mem_data_b;
  logic [7:0] rdata_b = 8'h00;

  logic [7:0] mem_a [16];

  exp_t q_a[$];
  exp_t q_b[$];
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  init_sequencer #(.BITS(8), .REG_SIZE(4), .MEMORY_SIZE(16), .FILL_VALUE(8'h00)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy_a), .done(done_a), .core_hold(core_hold_a),
    .reg_we(reg_we_a), .reg_addr(reg_addr_a), .reg_data(reg_data_a),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_data(mem_data_a),
    .mem_rdata(rdata_a), .err(err_a), .err_addr(err_addr_a)
  );

  init_sequencer #(.BITS(8), .REG_SIZE(8), .MEMORY_SIZE(4), .FILL_VALUE(8'h00)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b),
    .busy(busy_b), .done(done_b), .core_hold(core_hold_b),
    .reg_we(reg_we_b), .reg_addr(reg_addr_b), .reg_data(reg_data_b),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_data(mem_data_b),
    .mem_rdata(rdata_b), .err(err_b), .err_addr(err_addr_b)
  );

  // Data memory behind dut_a; inject forces a bad read-back at addresses 7 and 11.
  always @(posedge clk) begin
    if (mem_we_a) mem_a[mem_addr_a] <= mem_data_a;
    rdata_a <= (inject && (mem_addr_a == 4'd7 || mem_addr_a == 4'd11)) ? 8'h5A : mem_a[mem_addr_a];
  end

  function automatic exp_t model(int r, int m, int k);
    exp_t e;
    int mx, c;
    e = '0;
    mx = (r > m) ? r : m;
    if (k == 0) begin
      e.busy = 1'b1;
    end else if (k <= mx) begin
      c = k - 1;
      e.busy     = 1'b1;
      e.reg_we   = (c < r);
      e.mem_we   = (c < m);
      e.chk_r    = (c < r);
      e.chk_m    = (c < m);
      e.reg_addr = 4'(c);
      e.mem_addr = 4'(c);
    end else if (VER && k <= mx + m + 1) begin
      c = k - mx - 1;
      e.busy = 1'b1;
      if (c < m) begin
        e.chk_m    = 1'b1;
        e.mem_addr = 4'(c);
      end
    end else begin
      e.done = 1'b1;
    end
    return e;
  endfunction

  task automatic push_a(int n);
    for (int k = 0; k < n; k++) q_a.push_back(model(4, 16, k));
  endtask

  task automatic push_b(int n);
    for (int k = 0; k < n; k++) q_b.push_back(model(8, 4, k));
  endtask

  // Pops one expectation per cycle; optionally pulses start so edge start_at samples it.
  task automatic score_a(string tag, int n, int start_at);
    exp_t e;
    logic bad;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      e = q_a.pop_front();
      bad = (busy_a !== e.busy) || (core_hold_a !== e.busy) || (done_a !== e.done) ||
            (reg_we_a !== e.reg_we) || (mem_we_a !== e.mem_we) ||
            (e.chk_r && ({2'b00, reg_addr_a} !== e.reg_addr)) ||
            (e.chk_m && (mem_addr_a !== e.mem_addr)) ||
            (e.reg_we && reg_data_a !== 8'h00) || (e.mem_we && mem_data_a !== 8'h00);
      checks++;
      if (bad)
        $display("FAIL %s k=%0d got busy=%b hold=%b done=%b rwe=%b ra=%0d mwe=%b ma=%0d expected busy=%b done=%b rwe=%b ra=%0d mwe=%b ma=%0d",
                 tag, i, busy_a, core_hold_a, done_a, reg_we_a, reg_addr_a, mem_we_a, mem_addr_a,
                 e.busy, e.done, e.reg_we, e.reg_addr, e.mem_we, e.mem_addr);
      else
        passed++;
      start = (i == start_at - 1);
    end
    start = 1'b0;
  endtask

  task automatic score_b(string tag, int n);
    exp_t e;
    logic bad;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      e = q_b.pop_front();
      bad = (busy_b !== e.busy) || (core_hold_b !== e.busy) || (done_b !== e.done) ||
            (reg_we_b !== e.reg_we) || (mem_we_b !== e.mem_we) ||
            (e.chk_r && ({1'b0, reg_addr_b} !== e.reg_addr)) ||
            (e.chk_m && ({2'b00, mem_addr_b} !== e.mem_addr));
      checks++;
      if (bad)
        $display("FAIL %s k=%0d got busy=%b done=%b rwe=%b ra=%0d mwe=%b ma=%0d expected busy=%b done=%b rwe=%b ra=%0d mwe=%b ma=%0d",
                 tag, i, busy_b, done_b, reg_we_b, reg_addr_b, mem_we_b, mem_addr_b,
                 e.busy, e.done, e.reg_we, e.reg_addr, e.mem_we, e.mem_addr);
      else
        passed++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy_a, core_hold_a, done_a, reg_we_a, mem_we_a, err_a} !== 6'b110000) begin
      $display("FAIL reset_ctrl_a got busy/hold/done/rwe/mwe/err=%b expected 110000",
               {busy_a, core_hold_a, done_a, reg_we_a, mem_we_a, err_a});
    end else passed++;
    checks++;
    if ({reg_addr_a, mem_addr_a, err_addr_a} !== 10'd0) begin
      $display("FAIL reset_addr_a got ra=%0d ma=%0d ea=%0d expected 0", reg_addr_a, mem_addr_a, err_addr_a);
    end else passed++;
    checks++;
    if ({busy_b, core_hold_b, done_b, reg_we_b, mem_we_b, err_b} !== 6'b110000) begin
      $display("FAIL reset_ctrl_b got %b expected 110000",
               {busy_b, core_hold_b, done_b, reg_we_b, mem_we_b, err_b});
    end else passed++;
  endtask

  task automatic test_basic();
    rst_n = 1'b1;
    push_a(N_A);
    score_a("basic", N_A, -1);
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    push_a(N_A);
    score_a("restart", N_A, -1);
  endtask

  task automatic test_start_ignored();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    push_a(N_A);
    score_a("start_ignored", N_A, 5);
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    push_a(9);
    score_a("pre_abort", 9, -1);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_a, core_hold_a, done_a, reg_we_a, mem_we_a} !== 5'b11000) begin
      $display("FAIL async_reset got busy/hold/done/rwe/mwe=%b expected 11000",
               {busy_a, core_hold_a, done_a, reg_we_a, mem_we_a});
    end else passed++;
    checks++;
    if ({reg_addr_a, mem_addr_a} !== 6'd0) begin
      $display("FAIL async_reset_addr got ra=%0d ma=%0d expected 0", reg_addr_a, mem_addr_a);
    end else passed++;
    #1;
    rst_n = 1'b1;
    push_a(N_A);
    score_a("after_abort", N_A, -1);
  endtask

  task automatic test_verify();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    inject = 1'b1;
    push_a(N_A);
    score_a("verify_seq", N_A, -1);
    checks++;
    if (err_a !== EXP_ERR || err_addr_a !== EXP_ERR_ADDR) begin
      $display("FAIL verify_err got err=%b addr=%0d expected err=%b addr=%0d",
               err_a, err_addr_a, EXP_ERR, EXP_ERR_ADDR);
    end else passed++;
    inject = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (err_a !== 1'b0 || err_addr_a !== 4'd0) begin
      $display("FAIL err_clear got err=%b addr=%0d expected err=0 addr=0", err_a, err_addr_a);
    end else passed++;
    push_a(N_A);
    score_a("verify_clean", N_A, -1);
    checks++;
    if (err_a !== 1'b0) begin
      $display("FAIL verify_clean_err got err=%b expected 0", err_a);
    end else passed++;
  endtask

  task automatic test_small();
    rst_n_b = 1'b1;
    push_b(N_B);
    score_b("small_8x4", N_B);
    checks++;
    if (err_b !== 1'b0) begin
      $display("FAIL small_err got err=%b expected 0", err_b);
    end else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    rst_n_b = 1'b0;
    start   = 1'b0;
    start_b = 1'b0;
    inject  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    test_verify();
    test_small();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/init_sequencer.md
INIT_SEQUENCER -- requirements
Module: init_sequencer

Interface
REQ-001 SHALL have parameter BITS, default 8, register/data word width.
REQ-002 SHALL have parameter REG_SIZE, default 4, number of register-bank entries to initialise (>=1).
REQ-003 SHALL have parameter MEMORY_SIZE, default 256, number of data-memory words to initialise (>=1).
REQ-004 SHALL have parameter FILL_VALUE, default 0, BITS-wide word written to every location.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on posedge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, restart request, sampled on posedge.
REQ-008 SHALL have port busy, output, 1, sequence in progress.
REQ-009 SHALL have port done, output, 1, sequence complete, held until next start or reset.
REQ-010 SHALL have port core_hold, output, 1, stalls the core and forces PC to 0; equals busy.
REQ-011 SHALL have ports reg_we (1), reg_addr ($clog2(REG_SIZE), min 1), reg_data (BITS), outputs, register-bank write port.
REQ-012 SHALL have ports mem_we (1), mem_addr ($clog2(MEMORY_SIZE), min 1), mem_data (BITS), outputs, data-memory write/read address port.
REQ-013 SHALL have port mem_rdata, input, BITS, data-memory read data, valid one cycle after mem_addr.
REQ-014 SHALL have ports err (1) and err_addr (mem_addr width), outputs, verify-failure flag and first failing address.

Function
REQ-015 SHALL implement FSM states ARM, CLEAR, VERIFY, DONE; the reset state is ARM.
REQ-016 ARM SHALL last exactly one cycle with busy=1 and both write enables 0, then go to CLEAR with cnt=0.
REQ-017 CLEAR SHALL use one counter cnt with width $clog2(max(REG_SIZE,MEMORY_SIZE))+1, so it does not wrap.
REQ-018 CLEAR SHALL drive reg_we=(cnt<REG_SIZE), mem_we=(cnt<MEMORY_SIZE), reg_addr and mem_addr = low bits of cnt, and reg_data=mem_data=FILL_VALUE.
REQ-019 CLEAR SHALL last max(REG_SIZE,MEMORY_SIZE) cycles, then go to VERIFY (macro defined) or DONE.
REQ-020 VERIFY SHALL present mem_addr=0..MEMORY_SIZE-1 with mem_we=0, compare each mem_rdata one cycle later against FILL_VALUE, and last MEMORY_SIZE+1 cycles.
REQ-021 On the first mismatch, VERIFY SHALL set err=1 and latch err_addr; later mismatches SHALL NOT change err_addr; err SHALL stay set until the next start or reset.
REQ-022 DONE SHALL drive busy=0, done=1, and all write enables 0.
REQ-023 start SHALL be ignored in ARM, CLEAR and VERIFY.
REQ-024 start seen in DONE SHALL go to ARM on the next edge, clear done, err and err_addr, and repeat the full sequence.
REQ-025 Outputs SHALL be decoded only from registered state/cnt, with no combinational path from start or mem_rdata to any output.

Reset
REQ-026 rst_n low SHALL immediately force: state=ARM, cnt=0, busy=1, core_hold=1, done=0, reg_we=0, mem_we=0, err=0, err_addr=0, and addresses 0.
REQ-027 Reset asserted mid-sequence SHALL abandon progress; after release the sequence restarts from address 0.

Configuration
REQ-028 Macro INIT_SEQ_VERIFY_EN SHALL control the VERIFY state.
- Defined: the VERIFY state exists and err/err_addr are live.
- Undefined: CLEAR goes directly to DONE, mem_rdata is ignored, and err/err_addr are tied to 0.

Verification
All scenarios use REG_SIZE=4, MEMORY_SIZE=16, FILL_VALUE=0 unless stated otherwise.
REQ-029 Release rst_n, macro undefined -> reg_we high on edges 1-4 (addr 0-3); mem_we high on edges 1-16 (addr 0-15); done=1 after edge 17.
REQ-030 Pulse start at edge 5 -> ignored; done still after edge 17.
REQ-031 Pulse start while done=1 -> busy=1 on the next edge; done returns 17 edges later.
REQ-032 Drop rst_n at edge 8 -> write enables 0 and busy=1 immediately, with no clock; after release, writes restart at addr 0.
REQ-033 Define INIT_SEQ_VERIFY_EN, return mem_rdata=0x5A for addr 7 and 11 -> err=1, err_addr=7, done=1 after edge 34.
REQ-034 Set REG_SIZE=8, MEMORY_SIZE=4 -> mem_we high on edges 1-4 only; reg_we high on edges 1-8; done after edge 9.
